// File: rtl/rate_pkg.sv
`default_nettype none
// ============================================================================
// rate_pkg : shared types and helpers for the step rate generator
// Rev 1.0
// ============================================================================
package rate_pkg;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        PAUSED = 1'b1
    } run_state_t;

    localparam int LEVELS_DEFAULT = 8;

    function automatic int level_w(input int levels);
        return (levels > 1) ? $clog2(levels) : 1;
    endfunction

    localparam int LEVEL_W = level_w(LEVELS_DEFAULT);

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// button_debounce : 2-flop synchroniser, stability counter and press detect
// Rev 1.0
// ============================================================================
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int CNT_W           = 32
) (
    input  logic inclk,
    input  logic reset,
    input  logic raw,
    output logic db,
    output logic press
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    logic             db_q;
    logic             db_d;
    logic             db_dly_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync2_q != db_q) begin
            if (cnt_q == C_LAST) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + C_ONE;
            end
        end
    end

    // press is registered so the level/state update lands one edge after it
    always_ff @(posedge inclk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            db_q     <= db_d;
            db_dly_q <= db_q;
            press_q  <= db_q & ~db_dly_q;
            cnt_q    <= cnt_d;
        end
    end

    assign db    = db_q;
    assign press = press_q;

endmodule
`default_nettype wire

// File: rtl/step_rate_gen.sv
`default_nettype none
// ============================================================================
// step_rate_gen : button-controlled step tick / step clock divider
// Rev 1.0
// ============================================================================
module step_rate_gen
    import rate_pkg::*;
#(
    parameter int BASE_DIV        = 25_000_000,
    parameter int LEVELS          = 8,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int CNT_W           = 32
) (
    input  logic                         inclk,
    input  logic                         reset,
    input  logic                         btn_faster,
    input  logic                         btn_slower,
    input  logic                         btn_pause,
    output logic                         step_tick,
    output logic                         step_clk,
    output logic [level_w(LEVELS)-1:0]   level,
    output logic                         paused
);

    localparam int               LW        = level_w(LEVELS);
    localparam logic [CNT_W-1:0] C_BASE    = CNT_W'(BASE_DIV);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
    localparam logic [LW-1:0]    C_LVL_ONE = LW'(1);
    localparam logic [LW-1:0]    C_LVL_MAX = LW'(LEVELS - 1);

    logic [2:0]       w_raw;
    logic [2:0]       w_press;
    logic [2:0]       w_db_unused;

    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;
    run_state_t       state_q;
    run_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_q;
    logic             tick_d;
    logic             sclk_q;
    logic             sclk_d;

    logic [CNT_W-1:0] w_period;
    logic [CNT_W-1:0] w_half;
    logic             w_last;
    logic             w_up;
    logic             w_dn;
    logic             w_chg;

    assign w_raw = {btn_pause, btn_slower, btn_faster};

    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_db (
            .inclk (inclk),
            .reset (reset),
            .raw   (w_raw[gi]),
            .db    (w_db_unused[gi]),
            .press (w_press[gi])
        );
    end

    assign w_period = C_BASE >> level_q;
    assign w_half   = w_period >> 1;
    assign w_last   = (cnt_q == (w_period - C_ONE));

    // simultaneous faster+slower cancel; saturated presses are no-ops
    assign w_up  = w_press[0] & ~w_press[1] & (level_q != C_LVL_MAX);
    assign w_dn  = w_press[1] & ~w_press[0] & (level_q != '0);
    assign w_chg = w_up | w_dn;

    always_comb begin
        level_d = level_q;
        if (w_up) begin
            level_d = level_q + C_LVL_ONE;
        end else if (w_dn) begin
            level_d = level_q - C_LVL_ONE;
        end

        state_d = state_q;
        if (w_press[2]) begin
            state_d = (state_q == RUN) ? PAUSED : RUN;
        end

        cnt_d  = cnt_q;
        tick_d = 1'b0;
        sclk_d = sclk_q;
        if (state_q == RUN) begin
            sclk_d = (cnt_q < w_half);
            cnt_d  = w_last ? '0 : (cnt_q + C_ONE);
            tick_d = w_last & ~w_chg;
        end
        if (w_chg) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge inclk or posedge reset) begin
        if (reset) begin
            level_q <= '0;
            state_q <= RUN;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            sclk_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            sclk_q  <= sclk_d;
        end
    end

    assign step_tick = tick_q;
    assign step_clk  = sclk_q;
    assign level     = level_q;
    assign paused    = (state_q == PAUSED);

endmodule
`default_nettype wire

// File: tb/tb_step_rate_gen.sv
`default_nettype none
// ============================================================================
// tb_step_rate_gen : randomized scoreboard bench for step_rate_gen
// Rev 1.0
// ============================================================================
module tb_step_rate_gen;
    import rate_pkg::*;

    localparam int BASE_DIV = 256;
    localparam int LEVELS   = 8;
    localparam int DB       = 4;
    localparam int CNT_W    = 32;
    localparam int MAXE     = 65536;

    logic               inclk = 1'b0;
    logic               reset = 1'b1;
    logic               btn_faster = 1'b0;
    logic               btn_slower = 1'b0;
    logic               btn_pause  = 1'b0;
    logic               step_tick;
    logic               step_clk;
    logic [LEVEL_W-1:0] level;
    logic               paused;

    step_rate_gen #(
        .BASE_DIV        (BASE_DIV),
        .LEVELS          (LEVELS),
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (CNT_W)
    ) dut (
        .inclk      (inclk),
        .reset      (reset),
        .btn_faster (btn_faster),
        .btn_slower (btn_slower),
        .btn_pause  (btn_pause),
        .step_tick  (step_tick),
        .step_clk   (step_clk),
        .level      (level),
        .paused     (paused)
    );

    always #5 inclk = ~inclk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, exp, edge_n);
    endtask

    // Reference model: button effects are scheduled by edge number when the
    // stimulus is issued; the step timing is tracked as elapsed running steps.
    int  edge_n = 0;
    bit  ev_f [MAXE];
    bit  ev_s [MAXE];
    bit  ev_p [MAXE];
    int  m_lvl   = 0;
    bit  m_pz    = 0;
    bit  m_clk   = 0;
    int  m_steps = 0;
    int  exp_q [$];

    always @(posedge inclk) begin
        int per;
        bit up, dn;
        edge_n++;
        if (!reset && edge_n < MAXE) begin
            per = BASE_DIV >> m_lvl;
            up  = ev_f[edge_n] && !ev_s[edge_n] && (m_lvl < LEVELS - 1);
            dn  = ev_s[edge_n] && !ev_f[edge_n] && (m_lvl > 0);
            if (!m_pz) begin
                m_clk = (m_steps % per) < (per / 2);
                if (!(up || dn) && (m_steps % per) == per - 1) exp_q.push_back(edge_n);
                m_steps++;
            end
            if (up || dn) begin
                m_lvl   = up ? m_lvl + 1 : m_lvl - 1;
                m_steps = 0;
            end
            if (ev_p[edge_n]) m_pz = !m_pz;
        end
    end

    // Monitor: compare outputs every cycle, pop the tick scoreboard on each tick
    always @(negedge inclk) begin
        chk("level", level, m_lvl);
        chk("paused", paused, m_pz);
        chk("step_clk", step_clk, m_clk);
        if (step_tick) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL tick_unexpected: tick at edge %0d, none expected", edge_n);
            end else begin
                chk("tick_edge", edge_n, exp_q.pop_front());
            end
        end
        while (exp_q.size() > 0 && exp_q[0] < edge_n) begin
            n_chk++;
            $display("FAIL tick_missing: expected tick at edge %0d did not occur", exp_q.pop_front());
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge inclk);
            #1;
        end
    endtask

    // Raw level goes high at the next edge sample; a clean press takes effect
    // DB+3 edges after that first sample.
    task automatic press(input bit f, input bit s, input bit p, input int hi, input int lo);
        int eff;
        eff = edge_n + 1 + 3 + DB;
        if (hi >= DB && eff < MAXE) begin
            ev_f[eff] = f;
            ev_s[eff] = s;
            ev_p[eff] = p;
        end
        btn_faster = f;
        btn_slower = s;
        btn_pause  = p;
        cyc(hi);
        btn_faster = 1'b0;
        btn_slower = 1'b0;
        btn_pause  = 1'b0;
        cyc(lo);
    endtask

    task automatic model_reset();
        m_lvl   = 0;
        m_pz    = 0;
        m_clk   = 0;
        m_steps = 0;
        exp_q.delete();
        for (int i = 0; i < MAXE; i++) begin
            ev_f[i] = 0;
            ev_s[i] = 0;
            ev_p[i] = 0;
        end
    endtask

    initial begin
        int found;
        int r;
        int hi;
        int lo;

        cyc(3);
        chk("reset_level", level, 0);
        chk("reset_paused", paused, 0);
        chk("reset_tick", step_tick, 0);
        chk("reset_clk", step_clk, 0);
        reset = 1'b0;
        cyc(600);

        for (int i = 0; i < 3; i++) press(1, 0, 0, 10, 10);
        chk("level_after_3_faster", level, 3);
        cyc(100);

        for (int i = 0; i < 10; i++) press(1, 0, 0, $urandom_range(DB, DB + 8), $urandom_range(DB + 2, DB + 10));
        chk("level_sat_high", level, LEVELS - 1);
        cyc(20);
        for (int i = 0; i < 10; i++) press(0, 1, 0, $urandom_range(DB, DB + 8), $urandom_range(DB + 2, DB + 10));
        chk("level_sat_low", level, 0);
        cyc(300);

        press(1, 0, 0, 3, 10);
        press(1, 0, 0, 1, 10);
        press(0, 1, 0, 1, 10);
        press(0, 0, 1, 1, 10);
        chk("glitch_level", level, 0);
        chk("glitch_paused", paused, 0);
        cyc(50);

        found = 0;
        for (int i = 0; i < 600 && found == 0; i++) begin
            if (!m_pz && (m_steps % (BASE_DIV >> m_lvl)) == 93) found = 1;
            else cyc(1);
        end
        if (found == 0) begin
            n_chk++;
            $display("FAIL pause_align: counter target not reached, wanted phase 93");
        end
        press(0, 0, 1, 10, 10);
        chk("paused_set", paused, 1);
        cyc(1000);
        press(0, 0, 1, 10, 10);
        chk("paused_clear", paused, 0);
        cyc(300);

        press(1, 0, 0, 10, 10);
        press(1, 0, 0, 10, 10);
        press(1, 1, 0, 10, 10);
        chk("both_no_change", level, 2);
        cyc(50);

        for (int i = 0; i < 3; i++) press(1, 0, 0, 10, 10);
        press(0, 0, 1, 10, 10);
        chk("pre_reset_level", level, 5);
        chk("pre_reset_paused", paused, 1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_reset_level", level, 0);
        chk("async_reset_paused", paused, 0);
        chk("async_reset_tick", step_tick, 0);
        cyc(3);
        reset = 1'b0;
        cyc(600);

        for (int i = 0; i < 25; i++) begin
            r  = $urandom_range(0, 5);
            hi = $urandom_range(DB, DB + 8);
            lo = $urandom_range(DB + 2, DB + 10);
            case (r)
                0: press(1, 0, 0, hi, lo);
                1: press(0, 1, 0, hi, lo);
                2: press(0, 0, 1, hi, lo);
                3: press(1, 1, 0, hi, lo);
                4: press(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b0,
                         $urandom_range(1, DB - 1), lo);
                default: press(1, 0, 1, hi, lo);
            endcase
            cyc($urandom_range(0, 300));
        end

        cyc(20);
        @(negedge inclk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
